// File: rtl/control_turnos.sv
// control_turnos: turn sequencer for the 5x5 naval-battle game.
//
// It owns the tablero read/write port and alternates shots between the player and the PC.
// Each shot is resolved against the addressed cell, and the remaining ship cells are
// tracked for both sides. The player's turn has a timeout. The block declares win or loss.
//
// Ports
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   start                      level: IDLE -> P_WAIT, WIN/LOSE -> IDLE
//   fire, fire_row, fire_col   one-cycle player shot strobe and target
//   pc_valid, pc_row, pc_col   PC target handshake input
//   pc_req                     asks the PC generator for a target
//   brd_sel/row/col            registered board address (sel 0 = player, 1 = PC board)
//   brd_rd_data                combinational read of the addressed cell
//   brd_we, brd_wr_data        board write, combinational from state and read data
//   state                      current FSM state code
//   player_turn                high while the player may fire
//   ships_player, ships_pc     remaining ship cells per side
//   win, lose                  held game result
//   shot_invalid, timeout      one-cycle pulses
module control_turnos #(
    parameter int unsigned TURN_CYCLES = 750_000_000,
    parameter int unsigned NUM_SHIPS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       fire,
    input  logic [2:0] fire_row,
    input  logic [2:0] fire_col,
    input  logic       pc_valid,
    input  logic [2:0] pc_row,
    input  logic [2:0] pc_col,
    output logic       pc_req,
    output logic       brd_sel,
    output logic [2:0] brd_row,
    output logic [2:0] brd_col,
    input  logic [1:0] brd_rd_data,
    output logic       brd_we,
    output logic [1:0] brd_wr_data,
    output logic [2:0] state,
    output logic       player_turn,
    output logic [2:0] ships_player,
    output logic [2:0] ships_pc,
    output logic       win,
    output logic       lose,
    output logic       shot_invalid,
    output logic       timeout
);

    localparam int unsigned TimerW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TURN_CYCLES - 1);
    localparam logic [2:0] ShipsInit = 3'(NUM_SHIPS);

    localparam logic [1:0] CellWater = 2'b00;
    localparam logic [1:0] CellShip  = 2'b01;
    localparam logic [1:0] CellHit   = 2'b10;
    localparam logic [1:0] CellMiss  = 2'b11;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPWait  = 3'd1,
        StPRead  = 3'd2,
        StPcReq  = 3'd3,
        StPcRead = 3'd4,
        StWin    = 3'd5,
        StLose   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        ships_player_q, ships_player_d;
    logic [2:0]        ships_pc_q, ships_pc_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic              sel_q, sel_d;

    logic       fire_ok;
    logic       pc_ok;
    logic [2:0] ships_pc_dec;
    logic [2:0] ships_player_dec;

    assign fire_ok = (fire_row < 3'd5) && (fire_col < 3'd5);
    assign pc_ok   = (pc_row < 3'd5) && (pc_col < 3'd5);

    // Saturating decrements: a counter already at 0 stays at 0.
    assign ships_pc_dec     = (ships_pc_q != 3'd0) ? ships_pc_q - 3'd1 : 3'd0;
    assign ships_player_dec = (ships_player_q != 3'd0) ? ships_player_q - 3'd1 : 3'd0;

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        ships_player_d = ships_player_q;
        ships_pc_d     = ships_pc_q;
        row_d          = row_q;
        col_d          = col_q;
        sel_d          = sel_q;
        pc_req         = 1'b0;
        brd_we         = 1'b0;
        brd_wr_data    = CellWater;
        shot_invalid   = 1'b0;
        timeout        = 1'b0;
        player_turn    = 1'b0;
        win            = 1'b0;
        lose           = 1'b0;

        case (state_q)
            StIdle: begin
                ships_player_d = ShipsInit;
                ships_pc_d     = ShipsInit;
                timer_d        = '0;
                if (start) begin
                    state_d = StPWait;
                end
            end

            StPWait: begin
                player_turn = 1'b1;
                if (fire) begin
                    // A fire strobe always takes priority over expiry.
                    if (fire_ok) begin
                        row_d   = fire_row;
                        col_d   = fire_col;
                        sel_d   = 1'b1;
                        state_d = StPRead;
                    end else begin
                        shot_invalid = 1'b1;
                        if (timer_q != TimerMax) begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end else if (timer_q == TimerMax) begin
                    timeout = 1'b1;
                    state_d = StPcReq;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StPRead: begin
                case (brd_rd_data)
                    CellShip: begin
                        brd_we      = 1'b1;
                        brd_wr_data = CellHit;
                        ships_pc_d  = ships_pc_dec;
                        state_d     = (ships_pc_dec == 3'd0) ? StWin : StPcReq;
                    end
                    CellWater: begin
                        brd_we      = 1'b1;
                        brd_wr_data = CellMiss;
                        state_d     = (ships_pc_q == 3'd0) ? StWin : StPcReq;
                    end
                    default: begin
                        // Cell already shot: the player keeps the turn, timer untouched.
                        shot_invalid = 1'b1;
                        state_d      = StPWait;
                    end
                endcase
            end

            StPcReq: begin
                pc_req = 1'b1;
                if (pc_valid && pc_ok) begin
                    row_d   = pc_row;
                    col_d   = pc_col;
                    sel_d   = 1'b0;
                    state_d = StPcRead;
                end
            end

            StPcRead: begin
                case (brd_rd_data)
                    CellShip: begin
                        brd_we         = 1'b1;
                        brd_wr_data    = CellHit;
                        ships_player_d = ships_player_dec;
                        timer_d        = '0;
                        state_d        = (ships_player_dec == 3'd0) ? StLose : StPWait;
                    end
                    CellWater: begin
                        brd_we      = 1'b1;
                        brd_wr_data = CellMiss;
                        timer_d     = '0;
                        state_d     = (ships_player_q == 3'd0) ? StLose : StPWait;
                    end
                    default: begin
                        // Already-shot target: silently ask for another one.
                        state_d = StPcReq;
                    end
                endcase
            end

            StWin: begin
                win = 1'b1;
                if (start) begin
                    state_d = StIdle;
                end
            end

            StLose: begin
                lose = 1'b1;
                if (start) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            ships_player_q <= ShipsInit;
            ships_pc_q     <= ShipsInit;
            row_q          <= 3'd0;
            col_q          <= 3'd0;
            sel_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            ships_player_q <= ships_player_d;
            ships_pc_q     <= ships_pc_d;
            row_q          <= row_d;
            col_q          <= col_d;
            sel_q          <= sel_d;
        end
    end

    assign state        = state_q;
    assign brd_sel      = sel_q;
    assign brd_row      = row_q;
    assign brd_col      = col_q;
    assign ships_player = ships_player_q;
    assign ships_pc     = ships_pc_q;

endmodule
